// File: rtl/des_f_function_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | des_f_function_pipe : 2-stage DES round f(R,K) datapath (E^K -> S -> P)    |
// | Revision 1.0                                                               |
// +-----------------------------------------------------------------------------+
module des_f_function_pipe #(
   parameter int TAG_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [32:1]       i_r,
   input  logic [48:1]       i_k,
   input  logic [TAG_W-1:0]  i_tag,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [32:1]       o_f,
   output logic [TAG_W-1:0]  o_tag
);

   // Each ROM is 64 nibbles, row-major (row = {b1,b6}, col = b2..b5), entry 0 at the MSB.
   localparam logic [255:0] c_SBOX [1:8] = '{
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
      256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
   };

   localparam int c_P [1:32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
   };

   // Group j takes DES bits 4j-4..4j+1 of R, wrapping 0 -> 32 and 33 -> 1.
   function automatic logic [48:1] f_expand(input logic [32:1] r);
      logic [48:1] e;
      int          b;
      e = '0;
      for (int j = 1; j <= 8; j++) begin
         for (int k = 0; k < 6; k++) begin
            b = 4*j - 4 + k;
            if (b == 0)       b = 32;
            else if (b == 33) b = 1;
            e[54 - 6*j - k] = r[33 - b];
         end
      end
      return e;
   endfunction

   function automatic logic [32:1] f_perm(input logic [32:1] s);
      logic [32:1] p;
      p = '0;
      for (int n = 1; n <= 32; n++) begin
         p[33 - n] = s[33 - c_P[n]];
      end
      return p;
   endfunction

   logic              r_s1_valid;
   logic [48:1]       r_x;
   logic [TAG_W-1:0]  r_s1_tag;
   logic              r_out_valid;
   logic [32:1]       r_f;
   logic [TAG_W-1:0]  r_tag;

   logic              w_s2_adv;
   logic              w_s1_adv;
   logic              w_s1_load;
   logic              w_s2_load;
   logic [32:1]       w_s;
   logic [32:1]       w_f;

   assign w_s2_adv  = !r_out_valid || i_out_ready;
   assign w_s1_adv  = !r_s1_valid || w_s2_adv;
   assign w_s1_load = i_in_valid && w_s1_adv;
   assign w_s2_load = w_s2_adv && r_s1_valid;

   for (genvar j = 1; j <= 8; j++) begin : g_sbox
      logic [6:1] w_sel;
      logic [5:0] w_idx;
      assign w_sel = r_x[54 - 6*j -: 6];
      assign w_idx = {w_sel[6], w_sel[1], w_sel[5:2]};
      // 255 - 4*idx expressed as an 8-bit index: {~idx, 2'b11}.
      assign w_s[36 - 4*j -: 4] = c_SBOX[j][{~w_idx, 2'b11} -: 4];
   end

   assign w_f = f_perm(w_s);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_x        <= '0;
         r_s1_tag   <= '0;
      end else begin
         if (w_s1_adv) r_s1_valid <= i_in_valid;
         if (w_s1_load) begin
            r_x      <= f_expand(i_r) ^ i_k;
            r_s1_tag <= i_tag;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_f         <= '0;
         r_tag       <= '0;
      end else begin
         if (w_s2_adv) r_out_valid <= r_s1_valid;
         if (w_s2_load) begin
            r_f   <= w_f;
            r_tag <= r_s1_tag;
         end
      end
   end

   assign o_in_ready  = w_s1_adv;
   assign o_out_valid = r_out_valid;
   assign o_f         = r_f;
   assign o_tag       = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_des_f_function_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_des_f_function_pipe : directed vectors plus reference-model scoreboard  |
// | Revision 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_des_f_function_pipe;

   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [32:1]      r = '0;
   logic [48:1]      k = '0;
   logic [TAG_W-1:0] tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [32:1]      f_out;
   logic [TAG_W-1:0] out_tag;

   int checks = 0;
   int errors = 0;
   int n_out  = 0;

   always #5 clk = ~clk;

   des_f_function_pipe #(.TAG_W(TAG_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_r         (r),
      .i_k         (k),
      .i_tag       (tag),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_f         (f_out),
      .o_tag       (out_tag)
   );

   // Reference tables in DES bit numbering; S-boxes stored one 16-nibble row per word.
   localparam int E_T [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11,
                               12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
                               22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
   localparam int P_T [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                               2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
   localparam logic [63:0] SB [8][4] = '{
      '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
      '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
      '{64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
      '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
      '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
      '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
      '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
      '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
   };

   function automatic logic [32:1] model_f(input logic [32:1] rr, input logic [48:1] kk);
      logic [48:1] x;
      logic [32:1] s, p;
      logic [6:1]  b;
      logic [63:0] rowv;
      logic [3:0]  nib;
      int          row, col;
      for (int i = 1; i <= 48; i++) x[49-i] = rr[33-E_T[i-1]] ^ kk[49-i];
      for (int j = 1; j <= 8; j++) begin
         for (int m = 1; m <= 6; m++) b[7-m] = x[49-(6*(j-1)+m)];
         row  = 2*int'(b[6]) + int'(b[1]);
         col  = int'(b[5:2]);
         rowv = SB[j-1][row];
         nib  = rowv[63-4*col -: 4];
         for (int q = 0; q < 4; q++) s[33-(4*(j-1)+1+q)] = nib[3-q];
      end
      for (int n = 1; n <= 32; n++) p[33-n] = s[33-P_T[n-1]];
      return p;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [32:1]      f;
      logic [TAG_W-1:0] tag;
   } item_t;
   item_t sb_q[$];

   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            n_out++;
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: output %h with empty scoreboard, required none", f_out);
            end else begin
               item_t e;
               e = sb_q.pop_front();
               check("sb_f", f_out, e.f);
               check("sb_tag", out_tag, e.tag);
            end
         end
         if (in_valid && in_ready) sb_q.push_back('{model_f(r, k), tag});
      end
   end

   task automatic drain(input int budget);
      int c = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (sb_q.size() != 0 && c < budget) begin
         tick();
         c++;
      end
      check("drain_empty", sb_q.size(), 0);
   endtask

   typedef struct {
      logic [32:1]      r;
      logic [48:1]      k;
      logic [TAG_W-1:0] tag;
      logic [32:1]      f;
   } vec_t;
   vec_t vecs[5];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, idx, sent, cyc;
      logic acc;
      logic [32:1] held;

      vecs[0] = '{32'hF0AAF0AA, 48'h1B02EFFC7072, 4'd1, 32'h234AA9BB};
      vecs[1] = '{32'h00000000, 48'h000000000000, 4'd2, 32'hD8D8DBBC};
      vecs[2] = '{32'hEF4A6544, 48'h79AED9DBC9E5, 4'd3, 32'h3CAB87A3};
      vecs[3] = '{32'hFFFFFFFF, 48'hFFFFFFFFFFFF, 4'd15, 32'hD8D8DBBC};
      vecs[4] = '{32'hFFFFFFFF, 48'h000000000000, 4'd4, 32'h38DBF9CB};

      // Reset state
      tick(); tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_f_out", f_out, 0);
      check("rst_out_tag", out_tag, 0);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", in_ready, 1);

      // Directed vectors with latency check
      for (int i = 0; i < 5; i++) begin
         r = vecs[i].r; k = vecs[i].k; tag = vecs[i].tag; in_valid = 1'b1;
         #1;
         check("vec_in_ready", in_ready, 1);
         tick();
         in_valid = 1'b0;
         check("vec_lat1_valid", out_valid, 0);
         tick();
         check("vec_lat2_valid", out_valid, 1);
         check("vec_f", f_out, vecs[i].f);
         check("vec_tag", out_tag, vecs[i].tag);
         tick();
         check("vec_empty_after", out_valid, 0);
      end

      // Back-to-back stream of 16
      for (int c = 0; c < 18; c++) begin
         if (c < 16) begin
            in_valid = 1'b1; r = $urandom; k = {16'($urandom), $urandom}; tag = 4'(c);
         end else in_valid = 1'b0;
         #1;
         if (c < 16) check("stream_in_ready", in_ready, 1);
         check("stream_out_valid", out_valid, (c >= 2) ? 1 : 0);
         if (c >= 2) check("stream_tag", out_tag, 64'(c - 2));
         tick();
      end
      drain(20);

      // Stall: OUT_READY low for 5 cycles with a stream offered
      base = n_out; idx = 0; out_ready = 1'b0; held = '0;
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1; r = 32'h1234_0000 + idx; k = 48'hA5A5_0000_0000 + 48'(idx); tag = 4'(idx);
         #1;
         acc = in_ready;
         if (c == 2) held = f_out;
         tick();
         if (acc) idx++;
      end
      check("stall_accepted", idx, 2);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_f_stable", f_out, held);
      out_ready = 1'b1;
      cyc = 0;
      while (idx < 5 && cyc < 20) begin
         in_valid = 1'b1; r = 32'h1234_0000 + idx; k = 48'hA5A5_0000_0000 + 48'(idx); tag = 4'(idx);
         #1;
         acc = in_ready;
         tick();
         if (acc) idx++;
         cyc++;
      end
      drain(20);
      check("stall_out_count", n_out - base, 5);

      // Random handshakes
      base = n_out; sent = 0; cyc = 0; in_valid = 1'b0;
      while (sent < 3000 && cyc < 40000) begin
         out_ready = ($urandom_range(0, 9) < 7);
         if (!in_valid && $urandom_range(0, 3) != 0) begin
            in_valid = 1'b1; r = $urandom; k = {16'($urandom), $urandom}; tag = 4'($urandom);
         end
         #1;
         acc = in_valid && in_ready;
         tick();
         if (acc) begin
            sent++;
            in_valid = 1'b0;
         end
         cyc++;
      end
      check("rand_sent", sent, 3000);
      drain(50);
      check("rand_out_count", n_out - base, 3000);

      // Reset with two items in flight
      out_ready = 1'b0;
      in_valid = 1'b1; r = 32'hDEADBEEF; k = 48'h0123456789AB; tag = 4'd7;
      tick();
      r = 32'hCAFEF00D; tag = 4'd8;
      tick();
      in_valid = 1'b0;
      check("pre_rst_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_f_out", f_out, 0);
      check("midrst_out_tag", out_tag, 0);
      sb_q.delete();
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      r = vecs[0].r; k = vecs[0].k; tag = vecs[0].tag; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("postrst_lat1_valid", out_valid, 0);
      tick();
      check("postrst_lat2_valid", out_valid, 1);
      check("postrst_f", f_out, vecs[0].f);
      check("postrst_tag", out_tag, vecs[0].tag);
      drain(10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
